muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter W, default 8, operand and result width (4..32).
REQ-002 SHALL have parameter SAT_EN, default 1: 1 = saturate an oversize quotient, 0 = wrap to the low W bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports din_a, din_b, din_c  input  W  multiplicands a, b and divisor c.
REQ-006 SHALL have port din_mode  input  1  0 = truncate, 1 = round half up.
REQ-007 SHALL have port din_vld  input  1  input-valid strobe.
REQ-008 SHALL have port din_rdy  output  1  block can accept an operand set.
REQ-009 SHALL have port dout_y  output  W  result y = (a*b)/c.
REQ-010 SHALL have port dout_sat  output  1  quotient exceeded 2^W-1.
REQ-011 SHALL have port dout_dz  output  1  divisor was zero.
REQ-012 SHALL have port dout_vld  output  1  result-valid strobe.
REQ-013 SHALL have port dout_rdy  input  1  downstream accepts the result.

Function
REQ-014 SHALL accept a transfer when din_vld and din_rdy are both 1, registering a, b, c and mode.
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE; din_rdy SHALL be 1 only in IDLE.
REQ-016 SHALL move IDLE->MUL on accept; in MUL, SHALL form the 2W-bit product a*b in one cycle.
REQ-017 SHALL move MUL->DIV, except c==0: MUL->DONE with dout_y = all-ones, dout_dz=1, dout_sat=0.
REQ-018 SHALL perform a restoring division in DIV, one quotient bit per cycle, MSB first, for exactly 2W cycles, producing a 2W-bit quotient q and a W-bit remainder r.
REQ-019 SHALL, when mode=1, increment q if 2*r >= c (2*r compared at W+1 bits).
REQ-020 SHALL flag sat when the final q (after rounding) is >= 2^W; SAT_EN=1 -> dout_y = all-ones; SAT_EN=0 -> dout_y = q[W-1:0].
REQ-021 SHALL register dout_y and the flags on DIV->DONE; dout_vld SHALL be 1 only in DONE.
REQ-022 SHALL hold dout_y, the flags and dout_vld stable in DONE while dout_rdy=0.
REQ-023 SHALL move DONE->IDLE on dout_vld && dout_rdy; din_rdy rises the cycle after (no bypass).
REQ-024 SHALL give latency from accept edge to dout_vld high of 2W+2 cycles (2 cycles when c==0).
REQ-025 SHALL ignore din_vld in every state other than IDLE; no input is queued.
REQ-026 SHALL give a* b = 0 with c != 0 the result y=0, sat=0, dz=0.

Reset
REQ-027 SHALL, on rst=1, go to IDLE immediately and asynchronously, with din_rdy=1 (once rst=0), dout_vld=0, dout_y=0, dout_sat=0, dout_dz=0, and clear internal registers.
REQ-028 SHALL, when rst is asserted mid-DIV or in DONE, abort the operation and emit no result after release.

Structure
REQ-029 SHALL put the FSM state encoding and the mode constants (TRUNC=0, ROUND=1) in a shared package, muldiv_pkg.
REQ-030 SHALL place the division datapath in the sub-module seq_divider (start/busy/done, dividend 2W, divisor W); the FSM and multiply stay in the top level.

Verification (W=8, SAT_EN=1 unless stated)
REQ-031 SHALL check a=255, b=255, c=255, mode 0 -> y=255, sat=0, dz=0, dout_vld exactly 18 cycles after accept.
REQ-032 SHALL check a=0, b=99, c=99 -> y=0; then a=200, b=200, c=100 -> y=255, sat=1; with SAT_EN=0 -> y=144, sat=1.
REQ-033 SHALL check a=255, b=0, c=0 -> y=255, dz=1, dout_vld 2 cycles after accept.
REQ-034 SHALL check a=10, b=1, c=4: mode 0 -> y=2; mode 1 -> y=3. Also check a=7, b=1, c=4: mode 1 -> y=2.
REQ-035 SHALL hold dout_rdy=0 for 5 cycles in DONE -> outputs stable and din_rdy=0; a din_vld pulse during busy is dropped.
REQ-036 SHALL assert rst during DIV -> outputs reset immediately, no dout_vld afterwards, and the next operation is correct.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared FSM state encoding and rounding-mode constants for
//                the sequential multiply-divide block.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Controller state encoding
    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_MUL  = 2'd1;
    localparam state_t c_DIV  = 2'd2;
    localparam state_t c_DONE = 2'd3;

    // Rounding mode selected by din_mode
    localparam logic c_TRUNC = 1'b0;
    localparam logic c_ROUND = 1'b1;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Restoring divider, 2W-bit dividend by W-bit divisor. One
//                quotient bit per clock, MSB first; the first bit is resolved
//                on the start edge so 2W bits finish 2W-1 edges later.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder
);

    localparam int            CW       = $clog2(2 * W);
    localparam logic [CW-1:0] c_STEPS  = CW'(2 * W - 1);
    localparam logic [CW-1:0] c_ONE    = CW'(1);

    logic [W-1:0]   r_rem;
    logic [2*W-1:0] r_dvd;
    logic [W-1:0]   r_dsr;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;

    logic [W-1:0]   w_src_rem;
    logic [2*W-1:0] w_src_dvd;
    logic [W-1:0]   w_src_dsr;
    logic [W:0]     w_trial;
    logic [W:0]     w_diff;
    logic           w_ge;
    logic [W-1:0]   w_rem_nxt;
    logic [2*W-1:0] w_dvd_nxt;

    // One restoring step; on start it operates on the fresh operands
    always_comb begin
        w_src_rem = start ? '0       : r_rem;
        w_src_dvd = start ? dividend : r_dvd;
        w_src_dsr = start ? divisor  : r_dsr;
        w_trial   = {w_src_rem, w_src_dvd[2*W-1]};
        w_ge      = (w_trial >= {1'b0, w_src_dsr});
        w_diff    = w_trial - {1'b0, w_src_dsr};
        // The partial remainder stays below the divisor, so W bits suffice
        w_rem_nxt = w_ge ? w_diff[W-1:0] : w_trial[W-1:0];
        // Dividend bits shift out the top while quotient bits enter the bottom
        w_dvd_nxt = {w_src_dvd[2*W-2:0], w_ge};
    end

    // Iteration registers and step counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_rem  <= w_rem_nxt;
            r_dvd  <= w_dvd_nxt;
            r_dsr  <= divisor;
            r_cnt  <= c_STEPS;
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_dvd_nxt;
            r_cnt <= r_cnt - c_ONE;
            if (r_cnt == c_ONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_dvd;
    assign remainder = r_rem;

endmodule : seq_divider
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Sequential y = (a*b)/c with optional round-half-up,
//                quotient saturation and divide-by-zero flagging.
//                Valid/ready handshake on both sides, one operation in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int W      = 8,
    parameter int SAT_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din_a,
    input  logic [W-1:0] din_b,
    input  logic [W-1:0] din_c,
    input  logic         din_mode,
    input  logic         din_vld,
    output logic         din_rdy,
    output logic [W-1:0] dout_y,
    output logic         dout_sat,
    output logic         dout_dz,
    output logic         dout_vld,
    input  logic         dout_rdy
);

    state_t r_state;
    state_t w_state_nxt;

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_c;
    logic           r_mode;
    logic [W-1:0]   r_y;
    logic           r_sat;
    logic           r_dz;

    logic           w_accept;
    logic           w_c_zero;
    logic           w_div_start;
    logic           w_div_busy;
    logic           w_div_done;
    logic           w_div_fin;
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_quo;
    logic [W-1:0]   w_rem;
    logic           w_round_up;
    logic [2*W-1:0] w_q_fin;
    logic           w_sat;
    logic [W-1:0]   w_y_fin;

    assign w_c_zero  = (r_c == '0);
    assign w_div_fin = w_div_done && !w_div_busy;

    // Full-width product of the registered operands, formed during MUL
    assign w_prod = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (din_vld)   w_state_nxt = c_MUL;
            c_MUL:   w_state_nxt = w_c_zero ? c_DONE : c_DIV;
            c_DIV:   if (w_div_fin) w_state_nxt = c_DONE;
            c_DONE:  if (dout_rdy)  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State-decoded handshake and divider control
    always_comb begin
        din_rdy     = (r_state == c_IDLE);
        dout_vld    = (r_state == c_DONE);
        w_accept    = (r_state == c_IDLE) && din_vld;
        w_div_start = (r_state == c_MUL) && !w_c_zero;
    end

    seq_divider #(
        .W (W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .dividend  (w_prod),
        .divisor   (r_c),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Round half up: 2r >= c, compared at W+1 bits so 2r cannot overflow
    always_comb begin
        w_round_up = (r_mode == c_ROUND) && ({w_rem, 1'b0} >= {1'b0, r_c});
        w_q_fin    = w_quo + {{(2*W-1){1'b0}}, w_round_up};
        w_sat      = |w_q_fin[2*W-1:W];
        w_y_fin    = (w_sat && (SAT_EN != 0)) ? {W{1'b1}} : w_q_fin[W-1:0];
    end

    // Operand capture on accept and result capture on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_mode <= c_TRUNC;
            r_y    <= '0;
            r_sat  <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= din_a;
                r_b    <= din_b;
                r_c    <= din_c;
                r_mode <= din_mode;
            end
            if ((r_state == c_MUL) && w_c_zero) begin
                r_y   <= {W{1'b1}};
                r_sat <= 1'b0;
                r_dz  <= 1'b1;
            end else if ((r_state == c_DIV) && w_div_fin) begin
                r_y   <= w_y_fin;
                r_sat <= w_sat;
                r_dz  <= 1'b0;
            end
        end
    end

    assign dout_y   = r_y;
    assign dout_sat = r_sat;
    assign dout_dz  = r_dz;

endmodule : muldiv_seq
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Scoreboard bench for muldiv_seq. Two instances share the
//                inputs: one saturating, one wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_a = '0, din_b = '0, din_c = '0;
    logic       din_mode = 1'b0;
    logic       din_vld  = 1'b0;
    logic       dout_rdy = 1'b1;

    logic       rdy_s, rdy_w;
    logic [7:0] y_s, y_w;
    logic       sat_s, sat_w, dz_s, dz_w, vld_s, vld_w;

    typedef struct {
        logic [7:0] y_sat;
        logic [7:0] y_wrap;
        logic       sat;
        logic       dz;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.W(8), .SAT_EN(1)) dut_sat (
        .clk(clk), .rst(rst), .din_a(din_a), .din_b(din_b), .din_c(din_c),
        .din_mode(din_mode), .din_vld(din_vld), .din_rdy(rdy_s),
        .dout_y(y_s), .dout_sat(sat_s), .dout_dz(dz_s), .dout_vld(vld_s),
        .dout_rdy(dout_rdy)
    );

    muldiv_seq #(.W(8), .SAT_EN(0)) dut_wrap (
        .clk(clk), .rst(rst), .din_a(din_a), .din_b(din_b), .din_c(din_c),
        .din_mode(din_mode), .din_vld(din_vld), .din_rdy(rdy_w),
        .dout_y(y_w), .dout_sat(sat_w), .dout_dz(dz_w), .dout_vld(vld_w),
        .dout_rdy(dout_rdy)
    );

    task automatic check(input bit ok, input string name, input string got, input string want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %s want %s", name, got, want);
        end
    endtask

    // Monitor: pop and compare whenever a result is handed off
    always @(negedge clk) begin
        if (!rst && vld_s && dout_rdy) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_result", $sformatf("y=%0d", y_s), "no result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({y_s, sat_s, dz_s} == {e.y_sat, e.sat, e.dz}, {e.name, "_sat"},
                      $sformatf("y=%0d sat=%0d dz=%0d", y_s, sat_s, dz_s),
                      $sformatf("y=%0d sat=%0d dz=%0d", e.y_sat, e.sat, e.dz));
                check({vld_w, y_w, sat_w, dz_w} == {1'b1, e.y_wrap, e.sat, e.dz}, {e.name, "_wrap"},
                      $sformatf("vld=%0d y=%0d sat=%0d dz=%0d", vld_w, y_w, sat_w, dz_w),
                      $sformatf("vld=1 y=%0d sat=%0d dz=%0d", e.y_wrap, e.sat, e.dz));
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic mode, input logic [7:0] ey_sat, input logic [7:0] ey_wrap,
                          input logic esat, input logic edz, input int elat,
                          input int hold, input bit pulse, input string name);
        int  waitc;
        int  lat;
        bit  seen;
        exp_t e;
        waitc = 0;
        @(negedge clk);
        while (!rdy_s && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check(rdy_s, {name, "_din_rdy"}, $sformatf("%0d", rdy_s), "1");
        din_a = a; din_b = b; din_c = c; din_mode = mode; din_vld = 1'b1;
        if (hold > 0) dout_rdy = 1'b0;
        @(posedge clk);
        #1 din_vld = 1'b0;
        e.y_sat = ey_sat; e.y_wrap = ey_wrap; e.sat = esat; e.dz = edz; e.name = name;
        sb.push_back(e);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (pulse && lat == 4) begin
                check(!rdy_s, {name, "_busy_rdy"}, $sformatf("%0d", rdy_s), "0");
                din_a = 8'h11; din_b = 8'h22; din_c = 8'h03; din_vld = 1'b1;
            end else begin
                din_vld = 1'b0;
            end
            if (vld_s) seen = 1'b1;
        end
        check(seen && lat == elat, {name, "_latency"},
              $sformatf("seen=%0d lat=%0d", seen, lat), $sformatf("lat=%0d", elat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({vld_s, rdy_s, y_s, sat_s, dz_s} == {1'b1, 1'b0, ey_sat, esat, edz},
                  {name, "_hold"},
                  $sformatf("vld=%0d rdy=%0d y=%0d sat=%0d dz=%0d", vld_s, rdy_s, y_s, sat_s, dz_s),
                  $sformatf("vld=1 rdy=0 y=%0d sat=%0d dz=%0d", ey_sat, esat, edz));
        end
        dout_rdy = 1'b1;
        waitc = 0;
        while (vld_s && waitc < 20) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        check(!vld_s, {name, "_vld_drop"}, $sformatf("%0d", vld_s), "0");
    endtask

    task automatic abort_op();
        int vcnt;
        @(negedge clk);
        din_a = 8'd250; din_b = 8'd250; din_c = 8'd3; din_mode = 1'b1; din_vld = 1'b1;
        @(posedge clk);
        #1 din_vld = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check({vld_s, y_s, sat_s, dz_s, vld_w, y_w} == '0, "abort_outputs",
              $sformatf("vld=%0d y=%0d sat=%0d dz=%0d wy=%0d", vld_s, y_s, sat_s, dz_s, y_w),
              "all zero");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check(rdy_s && rdy_w, "abort_din_rdy", $sformatf("%0d/%0d", rdy_s, rdy_w), "1/1");
        vcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (vld_s || vld_w) vcnt++;
        end
        check(vcnt == 0, "abort_no_result", $sformatf("%0d valid cycles", vcnt), "0");
    endtask

    initial begin
        #1;
        check({vld_s, y_s, sat_s, dz_s} == '0, "reset_outputs",
              $sformatf("vld=%0d y=%0d sat=%0d dz=%0d", vld_s, y_s, sat_s, dz_s), "all zero");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check(rdy_s && rdy_w && !vld_w, "reset_din_rdy",
              $sformatf("rdy=%0d/%0d vld_w=%0d", rdy_s, rdy_w, vld_w), "rdy=1/1 vld_w=0");

        run_op(8'd255, 8'd255, 8'd255, 1'b0, 8'd255, 8'd255, 1'b0, 1'b0, 18, 0, 1'b0, "max_exact");
        run_op(8'd0,   8'd99,  8'd99,  1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 18, 0, 1'b0, "zero_prod");
        run_op(8'd200, 8'd200, 8'd100, 1'b0, 8'd255, 8'd144, 1'b1, 1'b0, 18, 0, 1'b0, "oversize");
        run_op(8'd255, 8'd0,   8'd0,   1'b0, 8'd255, 8'd255, 1'b0, 1'b1, 2,  0, 1'b0, "div_zero");
        run_op(8'd10,  8'd1,   8'd4,   1'b0, 8'd2,   8'd2,   1'b0, 1'b0, 18, 0, 1'b0, "trunc_10_4");
        run_op(8'd10,  8'd1,   8'd4,   1'b1, 8'd3,   8'd3,   1'b0, 1'b0, 18, 0, 1'b0, "round_10_4");
        run_op(8'd7,   8'd1,   8'd4,   1'b1, 8'd2,   8'd2,   1'b0, 1'b0, 18, 0, 1'b0, "round_7_4");
        run_op(8'd7,   8'd73,  8'd2,   1'b1, 8'd255, 8'd0,   1'b1, 1'b0, 18, 0, 1'b0, "round_to_sat");
        run_op(8'd100, 8'd3,   8'd7,   1'b1, 8'd43,  8'd43,  1'b0, 1'b0, 18, 5, 1'b0, "backpressure");
        run_op(8'd50,  8'd50,  8'd10,  1'b0, 8'd250, 8'd250, 1'b0, 1'b0, 18, 0, 1'b1, "busy_drop");
        abort_op();
        run_op(8'd12,  8'd12,  8'd5,   1'b1, 8'd29,  8'd29,  1'b0, 1'b0, 18, 0, 1'b0, "after_abort");

        repeat (40) @(negedge clk);
        check(sb.size() == 0, "scoreboard_empty", $sformatf("%0d pending", sb.size()), "0 pending");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_muldiv_seq
`default_nettype wire
